// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin scheduler sharing one APB master port
// between NUM_REQ held-request sources, with a wait-state timeout guard.
module apb_master_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
  input  logic [NUM_REQ*3-1:0]              req_prot,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_slverr,
  output logic                              psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [ADDR_WIDTH-1:0]             paddr,
  output logic [DATA_WIDTH-1:0]             pwdata,
  output logic [DATA_WIDTH/8-1:0]           pstrb,
  output logic [2:0]                        pprot,
  input  logic                              pready,
  input  logic                              pslverr,
  input  logic [DATA_WIDTH-1:0]             prdata,
  output logic                              busy
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]       pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;

  logic                done;
  logic                timed_out;
  logic [NUM_REQ-1:0]  elig;
  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic [IW-1:0]       cand;
  logic                take;

  // Completion detection (pready or wait-state timeout) and eligibility mask
  always_comb begin
    done      = 1'b0;
    timed_out = 1'b0;
    if (state_q == S_ACCESS) begin
      if (pready) begin
        done = 1'b1;
      end else if (TIMEOUT != 0 && tcnt_q == CW'(TIMEOUT - 1)) begin
        done      = 1'b1;
        timed_out = 1'b1;
      end
    end
    elig = req_valid & ~rsp_valid_q;
    if (done) elig[ptr_q] = 1'b0;
  end

  // Round-robin search starting one past the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, bus field capture and response generation
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    tcnt_d       = tcnt_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pprot_d      = pprot_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    take         = 1'b0;
    unique case (state_q)
      S_IDLE: take = win_found;
      S_SETUP: begin
        state_d = S_ACCESS;
        tcnt_d  = '0;
      end
      S_ACCESS: begin
        if (done) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_slverr_d       = timed_out | pslverr;
          rsp_rdata_d        = (pwrite_q || timed_out) ? '0 : prdata;
          state_d            = S_IDLE;
          take               = win_found;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Grant from IDLE or straight out of a completion (back-to-back SETUP)
    if (take) begin
      state_d  = S_SETUP;
      ptr_d    = win_idx;
      pwrite_d = req_write[win_idx];
      paddr_d  = req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      pwdata_d = req_wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      pstrb_d  = req_strb[32'(win_idx)*SW +: SW];
      pprot_d  = req_prot[32'(win_idx)*3 +: 3];
    end
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= S_IDLE;
      ptr_q        <= IW'(NUM_REQ - 1);
      tcnt_q       <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tcnt_q       <= tcnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pprot_q      <= pprot_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign busy       = psel_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = pstrb_q;
  assign pprot      = pprot_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule
